// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bridge
// Description : Bridges the memory-stage data-RAM request onto a req/ack
//               external data bus. Stalls the pipeline until the bus
//               transaction completes, aborts after a bus timeout, and
//               optionally posts stores into a one-entry write buffer.
// Options     : DMEM_WRITE_POST_EN - when defined, stores are posted and
//               drained in the background; later requests wait for the drain.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bridge #(
  // Maximum BUS-state cycles awaiting bus_ack_i; must be at least 2.
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active low
  input  logic        cpu_ce_i,
  input  logic        cpu_rd_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_we_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  output logic        bus_req_o,
  output logic        bus_wr_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             posted_q, posted_d;

  logic             w_start;
  logic             w_post;
  logic             unused_addr_lsbs;

  // Byte offset is expressed through the lanes; the bus sees a word address.
  assign unused_addr_lsbs = ^cpu_addr_i[1:0];

  // A store with no lanes enabled completes without touching the bus.
  assign w_start = cpu_ce_i & (cpu_rd_i | (cpu_we_i != 4'b0000));

`ifdef DMEM_WRITE_POST_EN
  // Stores are posted; the buffer is always empty while in IDLE.
  assign w_post = cpu_ce_i & ~cpu_rd_i & (cpu_we_i != 4'b0000);
`else
  assign w_post = 1'b0;
`endif

  // Next-state and datapath capture for the IDLE/BUS/DONE handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    posted_d = posted_q;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          state_d  = S_BUS;
          req_d    = 1'b1;
          wr_d     = ~cpu_rd_i;
          rd_d     = cpu_rd_i;
          addr_d   = {cpu_addr_i[31:2], 2'b00};
          be_d     = cpu_rd_i ? 4'b1111 : cpu_we_i;
          wdata_d  = cpu_data_i;
          cnt_d    = '0;
          posted_d = w_post;
        end
      end
      S_BUS: begin
        // An ack in the final timeout cycle still wins over the error.
        if (bus_ack_i) begin
          req_d    = 1'b0;
          cnt_d    = '0;
          posted_d = 1'b0;
          if (rd_q) rdata_d = bus_rdata_i;
          // A drained posted write returns straight to IDLE so that the
          // request it held off is serviced there rather than skipped.
          state_d  = posted_q ? S_IDLE : S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d    = 1'b0;
          cnt_d    = '0;
          err_d    = 1'b1;
          posted_d = 1'b0;
          if (rd_q) rdata_d = ERR_DATA;
          state_d  = posted_q ? S_IDLE : S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stall whenever the pipeline must wait for the bus; never during reset.
  always_comb begin
    stallreq = 1'b0;
    case (state_q)
      S_IDLE:  stallreq = w_start & ~w_post;
      S_BUS:   stallreq = posted_q ? cpu_ce_i : 1'b1;
      default: stallreq = 1'b0;
    endcase
    stallreq = stallreq & rst;
  end

  // State and bus registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      posted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      posted_q <= posted_d;
    end
  end

  assign cpu_data_o  = rdata_q;
  assign bus_req_o   = req_q;
  assign bus_wr_o    = wr_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign bus_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bridge
// Description : Directed self-checking bench for dmem_bridge. Expected bus
//               transactions and load data are queued as stimulus is driven
//               and compared when the bridge issues them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        cpu_ce_i;
  logic        cpu_rd_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_we_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        bus_req_o;
  logic        bus_wr_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  bus_t        exp_bus_q[$];
  logic [31:0] exp_data_q[$];

  int n_cmp = 0;
  int n_err = 0;

  dmem_bridge #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_DATA      (ERR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_rd_i   (cpu_rd_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq   (stallreq),
    .bus_req_o  (bus_req_o),
    .bus_wr_o   (bus_wr_o),
    .bus_addr_o (bus_addr_o),
    .bus_be_o   (bus_be_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i  (bus_ack_i),
    .bus_err_o  (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request and act as the bus slave until the stall releases.
  task automatic access(input logic rd, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input int ack_wait, input bit no_ack);
    int   stalls;
    int   waits;
    bit   seen;
    bit   done;
    bus_t e;
    @(negedge clk);
    cpu_ce_i   = 1'b1;
    cpu_rd_i   = rd;
    cpu_addr_i = addr;
    cpu_we_i   = we;
    cpu_data_i = data;
    exp_bus_q.push_back('{wr: ~rd, addr: {addr[31:2], 2'b00}, be: (rd ? 4'b1111 : we), wdata: data});
    if (rd) exp_data_q.push_back(no_ack ? ERR : rdata);
    stalls = 0; waits = 0; seen = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (c == 0) chk("req_low_in_idle", {31'd0, bus_req_o}, 32'd0);
      if (bus_req_o && !seen && exp_bus_q.size() > 0) begin
        seen = 1;
        e = exp_bus_q.pop_front();
        chk("bus_addr", bus_addr_o, e.addr);
        chk("bus_be", {28'd0, bus_be_o}, {28'd0, e.be});
        chk("bus_wr", {31'd0, bus_wr_o}, {31'd0, e.wr});
        if (e.wr) chk("bus_wdata", bus_wdata_o, e.wdata);
      end
      if (bus_req_o && !no_ack) begin
        if (waits == ack_wait) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = rdata;
        end
        waits++;
      end
      if (stallreq) begin
        stalls++;
        @(negedge clk);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
      end else begin
        done = 1;
      end
    end
    chk("stall_bound", {31'd0, done}, 32'd1);
    chk("bus_seen", {31'd0, seen}, 32'd1);
    chk("stall_cycles", stalls, no_ack ? (1 + TMO) : (2 + ack_wait));
    chk("req_low_done", {31'd0, bus_req_o}, 32'd0);
    chk("err_at_done", {31'd0, bus_err_o}, {31'd0, no_ack});
    if (rd && exp_data_q.size() > 0) chk("load_data", cpu_data_o, exp_data_q.pop_front());
    cpu_ce_i = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    cpu_ce_i    = 1'b0;
    cpu_rd_i    = 1'b0;
    cpu_addr_i  = 32'h0;
    cpu_we_i    = 4'h0;
    cpu_data_i  = 32'h0;
    bus_rdata_i = 32'h0;
    bus_ack_i   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stallreq}, 32'd0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_be", {28'd0, bus_be_o}, 32'd0);
    chk("rst_data", cpu_data_o, 32'h0);
    chk("rst_err", {31'd0, bus_err_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Load with ack in the first bus cycle
    access(1'b1, 32'h0000_0100, 4'b0000, 32'h0, 32'h1122_3344, 0, 0);

`ifndef DMEM_WRITE_POST_EN
    // Byte store with three wait cycles
    access(1'b0, 32'h0000_0203, 4'b0001, 32'hAAAA_AAAA, 32'h0, 3, 0);
`endif

    // Store with no lanes: no stall, no bus access
    @(negedge clk);
    cpu_ce_i = 1'b1; cpu_rd_i = 1'b0; cpu_addr_i = 32'h0000_0300; cpu_we_i = 4'b0000;
    #1 chk("zero_be_stall", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    cpu_ce_i = 1'b0;
    #1 chk("zero_be_noreq", {31'd0, bus_req_o}, 32'd0);

    // Load timeout
    access(1'b1, 32'h0000_0104, 4'b0000, 32'h0, 32'h0, 0, 1);
    @(negedge clk);
    #1 chk("err_one_pulse", {31'd0, bus_err_o}, 32'd0);

    // Load with a stray ack while idle, then back-to-back load/store
    bus_ack_i = 1'b1; bus_rdata_i = 32'h9999_9999;
    @(negedge clk);
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    #1 chk("idle_ack_ignored", cpu_data_o, ERR);
    access(1'b1, 32'h0000_0400, 4'b0000, 32'h0, 32'hCAFE_F00D, 0, 0);
`ifndef DMEM_WRITE_POST_EN
    access(1'b0, 32'h0000_0405, 4'b0100, 32'h7777_7777, 32'h0, 0, 0);
`endif
    access(1'b1, 32'h0000_0408, 4'b1010, 32'h0, 32'h5A5A_0001, 1, 0);

    // Reset in the middle of a bus wait
    @(negedge clk);
    cpu_ce_i = 1'b1; cpu_rd_i = 1'b1; cpu_addr_i = 32'h0000_0500; cpu_we_i = 4'b0000;
    repeat (2) @(negedge clk);
    #1 chk("pre_rst_req", {31'd0, bus_req_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("mid_rst_stall", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    rst = 1'b1; cpu_ce_i = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    #1;
    chk("post_rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("post_rst_data", cpu_data_o, 32'h0);
    chk("post_rst_stall", {31'd0, stallreq}, 32'd0);

`ifdef DMEM_WRITE_POST_EN
    // Posted store followed immediately by a load
    @(negedge clk);
    cpu_ce_i = 1'b1; cpu_rd_i = 1'b0; cpu_addr_i = 32'h0000_0600;
    cpu_we_i = 4'b1111; cpu_data_i = 32'h1234_5678;
    #1 chk("post_no_stall", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h0000_0704; cpu_we_i = 4'b0000;
    #1;
    chk("post_drain_req", {31'd0, bus_req_o}, 32'd1);
    chk("post_drain_wr", {31'd0, bus_wr_o}, 32'd1);
    chk("post_drain_addr", bus_addr_o, 32'h0000_0600);
    chk("post_load_stall", {31'd0, stallreq}, 32'd1);
    bus_ack_i = 1'b1;
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    chk("post_idle_stall", {31'd0, stallreq}, 32'd1);
    chk("post_idle_req", {31'd0, bus_req_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("post_load_req", {31'd0, bus_req_o}, 32'd1);
    chk("post_load_wr", {31'd0, bus_wr_o}, 32'd0);
    chk("post_load_addr", bus_addr_o, 32'h0000_0704);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    @(negedge clk);
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    #1;
    chk("post_load_release", {31'd0, stallreq}, 32'd0);
    chk("post_load_data", cpu_data_o, 32'h0BAD_F00D);
    cpu_ce_i = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
